hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
Parametrised pipeline hazard controller for the in-order MIPS core. It replaces purely combinational stage-compare hazard detection with a per-register countdown scoreboard, a divider busy counter and an exception drain/flush state machine. It sits beside the D/E boundary, sees every issue attempt from D, and drives the stall, bubble, freeze and flush controls for all pipeline stages.

Parameters:
REG_BITS, 5, architectural register index width; NUM_REGS = 2**REG_BITS
LAT_WIDTH, 3, width of per-register latency counters and issue_lat_i
DIV_CYCLES, 34, cycles the divider is busy after an accepted divide (1..2**8-1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
issue_valid_i  in  1  D holds an instruction that wants to enter E this cycle
issue_rs_i  in  REG_BITS  source A index
issue_rs_used_i  in  1  source A is read
issue_rt_i  in  REG_BITS  source B index
issue_rt_used_i  in  1  source B is read
issue_rd_i  in  REG_BITS  destination index
issue_wr_i  in  1  instruction writes issue_rd_i
issue_lat_i  in  LAT_WIDTH  cycles before a consumer may issue (0 = fully bypassable)
issue_div_i  in  1  instruction starts a divide
issue_hilo_rd_i  in  1  instruction reads HI/LO
if_pending_i  in  1  fetch data not yet returned
dmem_pending_i  in  1  data memory access outstanding in M
excep_req_i  in  1  exception/interrupt request from M
stall_f_o  out  1  hold PC
stall_d_o  out  1  hold F/D register
bubble_e_o  out  1  load NOP into D/E register
freeze_o  out  1  hold D/E, E/M and M/W registers
flush_o  out  1  clear all pipeline registers (one cycle)
excep_busy_o  out  1  exception FSM not IDLE
div_busy_o  out  1  divider counter nonzero

Behaviour:
- Reset (rst high, async): all cnt[r]=0, div_cnt=0, FSM=IDLE; while rst is high all outputs are 0.
- Scoreboard: cnt[r] (LAT_WIDTH bits) for r=1..NUM_REGS-1; register 0 is never tracked and never stalls.
- raw = (rs_used && cnt[rs]!=0) || (rt_used && cnt[rt]!=0), ignoring index 0.
- waw = issue_wr_i && rd!=0 && cnt[rd] > issue_lat_i.
- divc = div_cnt!=0 && (issue_div_i || issue_hilo_rd_i).
- haz = issue_valid_i && (raw || waw || divc).
- stall_d_o = haz || if_pending_i || dmem_pending_i || FSM!=IDLE; stall_f_o = stall_d_o.
- freeze_o = dmem_pending_i && FSM!=FLUSH.
- bubble_e_o = stall_d_o && !freeze_o && !flush_o.
- accept = issue_valid_i && !stall_d_o.
- Counter update each cycle: if flush_o, clear all cnt and div_cnt. Else if freeze_o, hold all counters. Else decrement every nonzero cnt and div_cnt by 1. Then, on accept with issue_wr_i && rd!=0 && issue_lat_i!=0, load cnt[rd]=issue_lat_i; this load overrides the decrement of the same entry. On accept with issue_div_i, load div_cnt=DIV_CYCLES.
- div_busy_o = div_cnt!=0.
- Exception FSM (IDLE, DRAIN, FLUSH):
  - IDLE: on excep_req_i, go to DRAIN if dmem_pending_i, else go to FLUSH.
  - DRAIN: stay while dmem_pending_i; go to FLUSH when it drops.
  - FLUSH: flush_o=1 for exactly this one cycle, then return to IDLE.
  - excep_req_i is ignored outside IDLE. excep_busy_o = FSM!=IDLE.
- A simultaneous accept and excep_req_i in IDLE: the issue is accepted and counters load, then the next FLUSH clears them.
- rst asserted mid-DRAIN or mid-divide returns the block to the reset state immediately.

Test Plan:
- Load-use: accept load r5 with lat=1, next cycle issue rs=5 -> stall_d_o=1 and bubble_e_o=1 for 1 cycle, then accepted on the following cycle.
- ALU forwarding: accept rd=7 with lat=0, next cycle issue rs=7 -> no stall. Issue rs=0 with cnt activity on r0 attempts -> never stalls.
- Divide: accept div, then issue mfhi each cycle -> stall_d_o=1 for exactly 34 cycles, accepted on cycle 35; div_busy_o falls in the same cycle.
- Freeze: cnt[3]=2, dmem_pending_i=1 for 4 cycles -> freeze_o=1, cnt[3] stays 2, bubble_e_o=0; it resumes counting after pending clears.
- Exception with drain: excep_req_i while dmem_pending_i=1 for 3 cycles -> DRAIN for 3 cycles, then one cycle with flush_o=1, all counters 0, and IDLE on the next cycle.
- WAW: cnt[9]=3, issue wr rd=9 with lat=1 -> stall until cnt[9]<=1, then accepted and cnt[9]=1.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - per-register countdown scoreboard, divider busy counter and exception drain/flush control
// Drives stall, bubble, freeze and flush for the in-order pipeline from D-stage issue attempts.
module hazard_scoreboard #(
   parameter int REG_BITS   = 5,
   parameter int LAT_WIDTH  = 3,
   parameter int DIV_CYCLES = 34
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 issue_valid_i,
   input  logic [REG_BITS-1:0]  issue_rs_i,
   input  logic                 issue_rs_used_i,
   input  logic [REG_BITS-1:0]  issue_rt_i,
   input  logic                 issue_rt_used_i,
   input  logic [REG_BITS-1:0]  issue_rd_i,
   input  logic                 issue_wr_i,
   input  logic [LAT_WIDTH-1:0] issue_lat_i,
   input  logic                 issue_div_i,
   input  logic                 issue_hilo_rd_i,
   input  logic                 if_pending_i,
   input  logic                 dmem_pending_i,
   input  logic                 excep_req_i,
   output logic                 stall_f_o,
   output logic                 stall_d_o,
   output logic                 bubble_e_o,
   output logic                 freeze_o,
   output logic                 flush_o,
   output logic                 excep_busy_o,
   output logic                 div_busy_o
);

   localparam int NUM_REGS = 2**REG_BITS;

   typedef enum logic [1:0] {IDLE, DRAIN, FLUSH} state_t;

   state_t               state_q, state_d;
   logic [LAT_WIDTH-1:0] cnt_q [NUM_REGS];
   logic [LAT_WIDTH-1:0] cnt_d [NUM_REGS];
   logic [7:0]           div_cnt_q, div_cnt_d;

   logic raw, waw, divc, haz;
   logic stall_int, freeze_int, flush_int, accept;

   always_comb begin
      raw = (issue_rs_used_i && (issue_rs_i != '0) && (cnt_q[issue_rs_i] != '0)) ||
            (issue_rt_used_i && (issue_rt_i != '0) && (cnt_q[issue_rt_i] != '0));
      waw = issue_wr_i && (issue_rd_i != '0) && (cnt_q[issue_rd_i] > issue_lat_i);
      divc = (div_cnt_q != '0) && (issue_div_i || issue_hilo_rd_i);
      haz = issue_valid_i && (raw || waw || divc);

      flush_int  = (state_q == FLUSH);
      stall_int  = haz || if_pending_i || dmem_pending_i || (state_q != IDLE);
      freeze_int = dmem_pending_i && !flush_int;
      accept     = issue_valid_i && !stall_int;
   end

   // Outputs are forced low for as long as reset is held, regardless of the inputs.
   always_comb begin
      stall_d_o    = stall_int && !rst;
      stall_f_o    = stall_int && !rst;
      freeze_o     = freeze_int && !rst;
      flush_o      = flush_int && !rst;
      bubble_e_o   = stall_int && !freeze_int && !flush_int && !rst;
      excep_busy_o = (state_q != IDLE) && !rst;
      div_busy_o   = (div_cnt_q != '0) && !rst;
   end

   // A new load on accept takes precedence over the decrement of the same entry.
   always_comb begin
      for (int r = 0; r < NUM_REGS; r++) begin
         if (flush_int)
            cnt_d[r] = '0;
         else if (freeze_int || (cnt_q[r] == '0))
            cnt_d[r] = cnt_q[r];
         else
            cnt_d[r] = cnt_q[r] - LAT_WIDTH'(1);
      end
      if (accept && issue_wr_i && (issue_rd_i != '0) && (issue_lat_i != '0))
         cnt_d[issue_rd_i] = issue_lat_i;
      cnt_d[0] = '0;

      if (flush_int)
         div_cnt_d = '0;
      else if (freeze_int || (div_cnt_q == '0))
         div_cnt_d = div_cnt_q;
      else
         div_cnt_d = div_cnt_q - 8'd1;
      if (accept && issue_div_i)
         div_cnt_d = 8'(DIV_CYCLES);
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (excep_req_i) state_d = dmem_pending_i ? DRAIN : FLUSH;
         DRAIN:   if (!dmem_pending_i) state_d = FLUSH;
         FLUSH:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         div_cnt_q <= '0;
         for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= '0;
      end else begin
         state_q   <= state_d;
         div_cnt_q <= div_cnt_d;
         for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= cnt_d[r];
      end
   end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - scoreboard bench for hazard_scoreboard
// Driver predicts each cycle's controls from a rule-level model; a negedge monitor compares.
module tb_hazard_scoreboard;

   localparam int DIV = 34;

   logic       clk = 1'b1;
   logic       rst;
   logic       issue_valid_i, issue_rs_used_i, issue_rt_used_i, issue_wr_i;
   logic [4:0] issue_rs_i, issue_rt_i, issue_rd_i;
   logic [2:0] issue_lat_i;
   logic       issue_div_i, issue_hilo_rd_i, if_pending_i, dmem_pending_i, excep_req_i;
   logic       stall_f_o, stall_d_o, bubble_e_o, freeze_o, flush_o, excep_busy_o, div_busy_o;

   typedef struct packed {
      logic stall_f, stall_d, bubble, freeze, flush, ebusy, dbusy;
   } exp_t;

   exp_t exp_q[$];
   int   tests = 0;
   int   fails = 0;
   int   cyc = 0;

   int   cnt_m [32];
   int   div_m = 0;
   int   st_m = 0;   // 0 idle, 1 drain, 2 flush

   hazard_scoreboard #(.REG_BITS(5), .LAT_WIDTH(3), .DIV_CYCLES(DIV)) dut (
      .clk(clk), .rst(rst),
      .issue_valid_i(issue_valid_i), .issue_rs_i(issue_rs_i), .issue_rs_used_i(issue_rs_used_i),
      .issue_rt_i(issue_rt_i), .issue_rt_used_i(issue_rt_used_i), .issue_rd_i(issue_rd_i),
      .issue_wr_i(issue_wr_i), .issue_lat_i(issue_lat_i), .issue_div_i(issue_div_i),
      .issue_hilo_rd_i(issue_hilo_rd_i), .if_pending_i(if_pending_i),
      .dmem_pending_i(dmem_pending_i), .excep_req_i(excep_req_i),
      .stall_f_o(stall_f_o), .stall_d_o(stall_d_o), .bubble_e_o(bubble_e_o),
      .freeze_o(freeze_o), .flush_o(flush_o), .excep_busy_o(excep_busy_o), .div_busy_o(div_busy_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         chk("stall_f", int'(stall_f_o), int'(e.stall_f));
         chk("stall_d", int'(stall_d_o), int'(e.stall_d));
         chk("bubble_e", int'(bubble_e_o), int'(e.bubble));
         chk("freeze", int'(freeze_o), int'(e.freeze));
         chk("flush", int'(flush_o), int'(e.flush));
         chk("excep_busy", int'(excep_busy_o), int'(e.ebusy));
         chk("div_busy", int'(div_busy_o), int'(e.dbusy));
      end
   end

   task automatic idle_inputs();
      issue_valid_i = 0; issue_rs_i = 0; issue_rs_used_i = 0; issue_rt_i = 0; issue_rt_used_i = 0;
      issue_rd_i = 0; issue_wr_i = 0; issue_lat_i = 0; issue_div_i = 0; issue_hilo_rd_i = 0;
      if_pending_i = 0; dmem_pending_i = 0; excep_req_i = 0;
   endtask

   task automatic issue(input int rs, input bit rs_u, input int rd, input bit wr, input int lat);
      issue_valid_i = 1; issue_rs_i = 5'(rs); issue_rs_used_i = rs_u; issue_rt_used_i = 0;
      issue_rd_i = 5'(rd); issue_wr_i = wr; issue_lat_i = 3'(lat);
      issue_div_i = 0; issue_hilo_rd_i = 0;
   endtask

   // Predict this cycle's controls, queue them, then advance the model across the clock edge.
   task automatic step(output bit acc);
      exp_t e;
      int   nc [32];
      int   nd, ns;
      bit   raw, waw, divc, stall, flush, freeze;
      e = '0; acc = 0;
      for (int r = 0; r < 32; r++) nc[r] = 0;
      nd = 0; ns = 0;
      if (!rst) begin
         raw = (issue_rs_used_i && issue_rs_i != 0 && cnt_m[issue_rs_i] > 0) ||
               (issue_rt_used_i && issue_rt_i != 0 && cnt_m[issue_rt_i] > 0);
         waw = issue_wr_i && issue_rd_i != 0 && cnt_m[issue_rd_i] > int'(issue_lat_i);
         divc = div_m > 0 && (issue_div_i || issue_hilo_rd_i);
         stall = (issue_valid_i && (raw || waw || divc)) || if_pending_i || dmem_pending_i || st_m != 0;
         flush = (st_m == 2);
         freeze = dmem_pending_i && !flush;
         acc = issue_valid_i && !stall;
         e.stall_f = stall; e.stall_d = stall; e.freeze = freeze; e.flush = flush;
         e.bubble = stall && !freeze && !flush;
         e.ebusy = (st_m != 0); e.dbusy = (div_m > 0);
         for (int r = 0; r < 32; r++)
            nc[r] = flush ? 0 : freeze ? cnt_m[r] : (cnt_m[r] > 0 ? cnt_m[r] - 1 : 0);
         nd = flush ? 0 : freeze ? div_m : (div_m > 0 ? div_m - 1 : 0);
         if (acc && issue_wr_i && issue_rd_i != 0 && issue_lat_i != 0) nc[issue_rd_i] = int'(issue_lat_i);
         if (acc && issue_div_i) nd = DIV;
         if (st_m == 0) ns = excep_req_i ? (dmem_pending_i ? 1 : 2) : 0;
         else if (st_m == 1) ns = dmem_pending_i ? 1 : 2;
         else ns = 0;
      end
      exp_q.push_back(e);
      @(posedge clk);
      cnt_m = nc; div_m = nd; st_m = ns; cyc++;
      #1;
   endtask

   initial begin
      bit acc;
      int n;
      for (int r = 0; r < 32; r++) cnt_m[r] = 0;
      idle_inputs();
      rst = 1;
      if_pending_i = 1; dmem_pending_i = 1; issue_valid_i = 1;
      step(acc); step(acc);
      idle_inputs();
      rst = 0;
      step(acc);

      // load-use: one bubble then accept
      issue(0, 0, 5, 1, 1); step(acc);
      issue(5, 1, 6, 1, 0); #1;
      chk("loaduse_stall", int'(stall_d_o), 1);
      chk("loaduse_bubble", int'(bubble_e_o), 1);
      step(acc); #1;
      chk("loaduse_accept", int'(stall_d_o), 0);
      step(acc);

      // ALU forwarding and r0 never stalls
      issue(0, 0, 7, 1, 0); step(acc);
      issue(7, 1, 0, 1, 5); #1;
      chk("fwd_nostall", int'(stall_d_o), 0);
      step(acc);
      issue(0, 1, 0, 0, 0); #1;
      chk("r0_nostall", int'(stall_d_o), 0);
      step(acc);

      // divide followed by back-to-back mfhi attempts
      issue(0, 0, 0, 0, 0); issue_div_i = 1; step(acc);
      issue(0, 0, 0, 0, 0); issue_hilo_rd_i = 1;
      n = 0;
      for (int i = 0; i < 100; i++) begin
         #1;
         if (!stall_d_o) break;
         n++;
         step(acc);
      end
      chk("div_stall_cycles", n, DIV);
      chk("div_busy_at_accept", int'(div_busy_o), 0);
      step(acc);

      // freeze holds counters while memory is pending
      issue(0, 0, 3, 1, 2); step(acc);
      issue(3, 1, 0, 0, 0); dmem_pending_i = 1; #1;
      chk("freeze_on", int'(freeze_o), 1);
      chk("freeze_nobubble", int'(bubble_e_o), 0);
      for (int i = 0; i < 4; i++) step(acc);
      dmem_pending_i = 0;
      n = 0;
      for (int i = 0; i < 10; i++) begin
         step(acc);
         if (acc) break;
         n++;
      end
      chk("freeze_resume_stalls", n, 2);

      // exception with drain; flush clears a pending long-latency counter
      idle_inputs(); issue(0, 0, 4, 1, 7); step(acc);
      idle_inputs(); dmem_pending_i = 1; excep_req_i = 1; step(acc);
      excep_req_i = 0;
      for (int i = 0; i < 3; i++) begin #1; chk("drain_busy", int'(excep_busy_o), 1); step(acc); end
      dmem_pending_i = 0; step(acc); #1;
      chk("flush_pulse", int'(flush_o), 1);
      step(acc);
      issue(4, 1, 0, 0, 0); #1;
      chk("flush_done", int'(flush_o), 0);
      chk("flush_cleared_cnt", int'(stall_d_o), 0);
      step(acc);

      // WAW on r9
      issue(0, 0, 9, 1, 3); step(acc);
      issue(0, 0, 9, 1, 1);
      n = 0;
      for (int i = 0; i < 10; i++) begin
         step(acc);
         if (acc) break;
         n++;
      end
      chk("waw_stalls", n, 2);
      issue(9, 1, 0, 0, 0); step(acc);

      // reset in the middle of a drain and a divide
      idle_inputs(); issue(0, 0, 0, 0, 0); issue_div_i = 1; step(acc);
      idle_inputs(); dmem_pending_i = 1; excep_req_i = 1; step(acc);
      excep_req_i = 0; step(acc);
      rst = 1; #1;
      chk("rst_drain_busy", int'(excep_busy_o), 0);
      chk("rst_div_busy", int'(div_busy_o), 0);
      chk("rst_stall", int'(stall_d_o), 0);
      step(acc);
      rst = 0; idle_inputs(); step(acc);

      // randomized traffic over a small register window to provoke hazards
      for (int i = 0; i < 2000; i++) begin
         issue_valid_i   = ($urandom_range(0, 9) < 8);
         issue_rs_i      = 5'($urandom_range(0, 7));
         issue_rs_used_i = 1'($urandom);
         issue_rt_i      = 5'($urandom_range(0, 7));
         issue_rt_used_i = 1'($urandom);
         issue_rd_i      = 5'($urandom_range(0, 7));
         issue_wr_i      = 1'($urandom);
         issue_lat_i     = 3'($urandom_range(0, 7));
         issue_div_i     = ($urandom_range(0, 99) < 4);
         issue_hilo_rd_i = ($urandom_range(0, 99) < 10);
         if_pending_i    = ($urandom_range(0, 99) < 10);
         dmem_pending_i  = ($urandom_range(0, 99) < 15);
         excep_req_i     = ($urandom_range(0, 99) < 3);
         rst             = ($urandom_range(0, 999) < 4);
         step(acc);
      end
      rst = 0; idle_inputs(); step(acc);

      @(negedge clk); #1;
      chk("queue_drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
